// File: rtl/d3s_frev_timestamper.sv
// d3s_frev_timestamper: detects RF phase wraps on a 4-lane 14-bit phase stream,
// divides the wrap rate by the harmonic number and stamps each selected wrap
// with latency-compensated WR time. The result is presented on a single-entry
// valid/ready output register.
module d3s_frev_timestamper #(
  parameter int unsigned g_wrap_divider    = 5,
  parameter int unsigned g_latency_comp_ns = 0,
  parameter int unsigned g_wrap_hi         = 12288,
  parameter int unsigned g_wrap_lo         = 4096
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [55:0] phase_i,
  input  logic        phase_valid_i,
  input  logic        enable_i,
  input  logic        tm_time_valid_i,
  input  logic [31:0] tm_tai_i,
  input  logic [27:0] tm_cycles_i,
  output logic [31:0] frev_ts_tai_o,
  output logic [31:0] frev_ts_nsec_o,
  output logic        frev_ts_valid_o,
  input  logic        frev_ts_ready_i,
  output logic        overflow_o
);

  localparam logic [13:0] WRAP_HI  = 14'(g_wrap_hi);
  localparam logic [13:0] WRAP_LO  = 14'(g_wrap_lo);
  localparam logic [3:0]  DIV_LAST = 4'(g_wrap_divider - 1);
  localparam logic signed [32:0] COMP_NS = 33'(g_latency_comp_ns);
  localparam logic signed [32:0] NS_PER_SEC = 33'sd1000000000;

  // ---------------- stage 1: wrap detect / lane encode ----------------
  logic [13:0] lane [4];
  logic [3:0]  wrap_vec;
  logic [13:0] ph3_hist_q, ph3_hist_d;
  logic        prev_ok_q, prev_ok_d;
  logic        s1_wrap_q, s1_wrap_d;
  logic [1:0]  s1_k_q, s1_k_d;
  logic [31:0] s1_tai_q, s1_tai_d;
  logic [27:0] s1_cyc_q, s1_cyc_d;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = phase_i[14*gi +: 14];
  end

  // Lane 0 pairs with the last lane of the previous valid word.
  assign wrap_vec[0] = prev_ok_q && (ph3_hist_q >= WRAP_HI) && (lane[0] < WRAP_LO);
  for (gi = 1; gi < 4; gi++) begin : g_pair
    assign wrap_vec[gi] = (lane[gi-1] >= WRAP_HI) && (lane[gi] < WRAP_LO);
  end

  // Pick the earliest wrapping lane; history tracks valid words only.
  always_comb begin
    s1_k_d = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (wrap_vec[i]) s1_k_d = 2'(i);
    end
    s1_wrap_d  = phase_valid_i && enable_i && tm_time_valid_i && (|wrap_vec);
    s1_tai_d   = tm_tai_i;
    s1_cyc_d   = tm_cycles_i;
    ph3_hist_d = phase_valid_i ? lane[3] : ph3_hist_q;
    prev_ok_d  = !enable_i ? 1'b0 : (phase_valid_i ? 1'b1 : prev_ok_q);
  end

  // ---------------- stage 2: raw ns and divider decision ----------------
  logic [3:0]  cnt_q, cnt_d;
  logic        s2_emit_q, s2_emit_d;
  logic [31:0] s2_ns_q, s2_ns_d;
  logic [31:0] s2_tai_q, s2_tai_d;

  // Emit on the wrap that finds the counter at zero, then advance modulo N.
  always_comb begin
    s2_emit_d = s1_wrap_q && (cnt_q == 4'd0);
    s2_ns_d   = {1'b0, s1_cyc_q, 3'b000} + {29'd0, s1_k_q, 1'b0};
    s2_tai_d  = s1_tai_q;
    cnt_d     = cnt_q;
    if (!enable_i) begin
      cnt_d = 4'd0;
    end else if (s1_wrap_q) begin
      cnt_d = (cnt_q >= DIV_LAST) ? 4'd0 : cnt_q + 4'd1;
    end
  end

  // ---------------- stage 3: latency compensation ----------------
  logic signed [32:0] comp_diff;
  logic signed [32:0] comp_wrapped;
  logic        s3_valid_q, s3_valid_d;
  logic [31:0] s3_ns_q, s3_ns_d;
  logic [31:0] s3_tai_q, s3_tai_d;

  // Subtract the latency; a negative result borrows one second.
  always_comb begin
    comp_diff    = $signed({1'b0, s2_ns_q}) - COMP_NS;
    comp_wrapped = comp_diff + NS_PER_SEC;
    s3_valid_d   = s2_emit_q;
    if (comp_diff[32]) begin
      s3_ns_d  = comp_wrapped[31:0];
      s3_tai_d = s2_tai_q - 32'd1;
    end else begin
      s3_ns_d  = comp_diff[31:0];
      s3_tai_d = s2_tai_q;
    end
  end

  // ---------------- output register ----------------
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_tai_q, out_tai_d;
  logic [31:0] out_ns_q, out_ns_d;
  logic        ovf_q, ovf_d;
  logic        accept;

  assign accept = out_valid_q && frev_ts_ready_i;

  // Single-entry holding register: load when free or draining, else drop and flag.
  always_comb begin
    out_valid_d = out_valid_q;
    out_tai_d   = out_tai_q;
    out_ns_d    = out_ns_q;
    ovf_d       = ovf_q;
    if (s3_valid_q) begin
      if (!out_valid_q || accept) begin
        out_valid_d = 1'b1;
        out_tai_d   = s3_tai_q;
        out_ns_d    = s3_ns_q;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (accept) begin
      out_valid_d = 1'b0;
    end
    if (!enable_i) ovf_d = 1'b0;
  end

  // All pipeline and output state, cleared by the synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ph3_hist_q  <= '0;
      prev_ok_q   <= 1'b0;
      s1_wrap_q   <= 1'b0;
      s1_k_q      <= '0;
      s1_tai_q    <= '0;
      s1_cyc_q    <= '0;
      cnt_q       <= '0;
      s2_emit_q   <= 1'b0;
      s2_ns_q     <= '0;
      s2_tai_q    <= '0;
      s3_valid_q  <= 1'b0;
      s3_ns_q     <= '0;
      s3_tai_q    <= '0;
      out_valid_q <= 1'b0;
      out_tai_q   <= '0;
      out_ns_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      ph3_hist_q  <= ph3_hist_d;
      prev_ok_q   <= prev_ok_d;
      s1_wrap_q   <= s1_wrap_d;
      s1_k_q      <= s1_k_d;
      s1_tai_q    <= s1_tai_d;
      s1_cyc_q    <= s1_cyc_d;
      cnt_q       <= cnt_d;
      s2_emit_q   <= s2_emit_d;
      s2_ns_q     <= s2_ns_d;
      s2_tai_q    <= s2_tai_d;
      s3_valid_q  <= s3_valid_d;
      s3_ns_q     <= s3_ns_d;
      s3_tai_q    <= s3_tai_d;
      out_valid_q <= out_valid_d;
      out_tai_q   <= out_tai_d;
      out_ns_q    <= out_ns_d;
      ovf_q       <= ovf_d;
    end
  end

  assign frev_ts_tai_o   = out_tai_q;
  assign frev_ts_nsec_o  = out_ns_q;
  assign frev_ts_valid_o = out_valid_q;
  assign overflow_o      = ovf_q;

endmodule

// File: tb/tb_d3s_frev_timestamper.sv
// Directed bench for d3s_frev_timestamper. Three instances share the stimulus:
// u_a (N=1, comp=0), u_b (N=5, comp=0), u_c (N=1, comp=24).
module tb_d3s_frev_timestamper;

  logic        clk = 1'b0;
  logic        rst_n, en, tvld, pvld, rdy;
  logic [55:0] phase;
  logic [31:0] tai;
  logic [27:0] cyc;

  logic [31:0] tai_a, nsec_a, tai_b, nsec_b, tai_c, nsec_c;
  logic        vld_a, ovf_a, vld_b, ovf_b, vld_c, ovf_c;

  int checks = 0;
  int failures = 0;

  // monitor state used by the divider test
  logic        mon = 1'b0;
  int          n1_cnt = 0;
  int          n5_cnt = 0;
  logic [31:0] n5_ns [4];

  always #4 clk = ~clk;

  d3s_frev_timestamper #(.g_wrap_divider(1), .g_latency_comp_ns(0)) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .phase_i(phase), .phase_valid_i(pvld),
    .enable_i(en), .tm_time_valid_i(tvld), .tm_tai_i(tai), .tm_cycles_i(cyc),
    .frev_ts_tai_o(tai_a), .frev_ts_nsec_o(nsec_a), .frev_ts_valid_o(vld_a),
    .frev_ts_ready_i(rdy), .overflow_o(ovf_a));

  d3s_frev_timestamper #(.g_wrap_divider(5), .g_latency_comp_ns(0)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .phase_i(phase), .phase_valid_i(pvld),
    .enable_i(en), .tm_time_valid_i(tvld), .tm_tai_i(tai), .tm_cycles_i(cyc),
    .frev_ts_tai_o(tai_b), .frev_ts_nsec_o(nsec_b), .frev_ts_valid_o(vld_b),
    .frev_ts_ready_i(rdy), .overflow_o(ovf_b));

  d3s_frev_timestamper #(.g_wrap_divider(1), .g_latency_comp_ns(24)) u_c (
    .clk_i(clk), .rst_n_i(rst_n), .phase_i(phase), .phase_valid_i(pvld),
    .enable_i(en), .tm_time_valid_i(tvld), .tm_tai_i(tai), .tm_cycles_i(cyc),
    .frev_ts_tai_o(tai_c), .frev_ts_nsec_o(nsec_c), .frev_ts_valid_o(vld_c),
    .frev_ts_ready_i(rdy), .overflow_o(ovf_c));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // advance n cycles, sampling 1 ns after each rising edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (mon) begin
        if (vld_a) n1_cnt++;
        if (vld_b) begin
          if (n5_cnt < 4) n5_ns[n5_cnt] = nsec_b;
          n5_cnt++;
        end
      end
    end
  endtask

  task automatic send(input logic [13:0] p0, input logic [13:0] p1,
                      input logic [13:0] p2, input logic [13:0] p3,
                      input logic [31:0] t, input logic [27:0] c);
    phase = {p3, p2, p1, p0};
    tai   = t;
    cyc   = c;
    pvld  = 1'b1;
    tick(1);
    pvld  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pvld  = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; tvld = 1'b1; pvld = 1'b0; rdy = 1'b1;
    phase = '0; tai = '0; cyc = '0;
    for (int i = 0; i < 4; i++) n5_ns[i] = '0;

    // reset values
    tick(3);
    chk("rst_vld", vld_a, 0);
    chk("rst_tai", tai_a, 0);
    chk("rst_nsec", nsec_a, 0);
    chk("rst_ovf", ovf_a, 0);

    // basic stamp, wrap at lane 1
    do_reset();
    send(15000, 15000, 15000, 15000, 7, 100);
    send(16000, 200, 1200, 2200, 7, 100);
    tick(2);
    chk("basic_latency_vld", vld_a, 0);
    tick(1);
    chk("basic_vld", vld_a, 1);
    chk("basic_tai", tai_a, 7);
    chk("basic_nsec", nsec_a, 802);
    chk("basic_comp24_nsec", nsec_c, 778);
    tick(1);
    chk("basic_accepted_vld", vld_a, 0);
    // wrap across words, lane 0
    send(15000, 15000, 15000, 15000, 7, 50);
    send(100, 5000, 5000, 5000, 7, 100);
    tick(3);
    chk("across_vld", vld_a, 1);
    chk("across_nsec", nsec_a, 800);
    chk("across_div5_skip", vld_b, 0);
    tick(2);

    // divider N=5 over 10 back-to-back wraps
    do_reset();
    n1_cnt = 0; n5_cnt = 0; mon = 1'b1;
    for (int i = 0; i < 10; i++) send(15000, 100, 5000, 5000, 3, 28'(1000 + i));
    tick(5);
    mon = 1'b0;
    chk("div5_count", n5_cnt, 2);
    chk("div5_first_nsec", n5_ns[0], 8002);
    chk("div5_second_nsec", n5_ns[1], 8042);
    chk("div1_count", n1_cnt, 10);
    // counter at 2 after two more wraps; toggling enable clears it
    send(15000, 100, 5000, 5000, 3, 1100);
    send(15000, 100, 5000, 5000, 3, 1101);
    tick(5);
    en = 1'b0;
    tick(2);
    en = 1'b1;
    n1_cnt = 0; n5_cnt = 0; mon = 1'b1;
    send(15000, 100, 5000, 5000, 3, 2000);
    tick(5);
    mon = 1'b0;
    chk("toggle_count", n5_cnt, 1);
    chk("toggle_nsec", n5_ns[0], 16002);

    // borrow with comp=24
    do_reset();
    send(15000, 15000, 15000, 15000, 7, 0);
    send(100, 5000, 5000, 5000, 7, 0);
    tick(3);
    chk("borrow_tai", tai_c, 6);
    chk("borrow_nsec", nsec_c, 999999976);
    chk("nocomp_zero_nsec", nsec_a, 0);
    tick(2);
    send(15000, 15000, 15000, 15000, 7, 3);
    send(100, 5000, 5000, 5000, 7, 3);
    tick(3);
    chk("noborrow_tai", tai_c, 7);
    chk("noborrow_nsec", nsec_c, 0);
    tick(2);

    // back-pressure on u_a
    do_reset();
    rdy = 1'b0;
    send(15000, 100, 5000, 5000, 1, 10);
    tick(3);
    chk("bp_first_vld", vld_a, 1);
    chk("bp_first_nsec", nsec_a, 82);
    chk("bp_first_ovf", ovf_a, 0);
    send(15000, 100, 5000, 5000, 1, 20);
    tick(4);
    chk("bp_hold_vld", vld_a, 1);
    chk("bp_hold_nsec", nsec_a, 82);
    chk("bp_drop_ovf", ovf_a, 1);
    send(15000, 100, 5000, 5000, 1, 30);
    tick(2);
    rdy = 1'b1;
    tick(1);
    chk("bp_swap_vld", vld_a, 1);
    chk("bp_swap_nsec", nsec_a, 242);
    chk("bp_ovf_sticky", ovf_a, 1);
    tick(1);
    chk("bp_drain_vld", vld_a, 0);
    rdy = 1'b0;
    send(15000, 100, 5000, 5000, 1, 40);
    tick(3);
    chk("en_pre_vld", vld_a, 1);
    chk("en_pre_ovf", ovf_a, 1);
    en = 1'b0;
    tick(2);
    chk("en_hold_vld", vld_a, 1);
    chk("en_hold_nsec", nsec_a, 322);
    chk("en_ovf_clear", ovf_a, 0);
    en = 1'b1;
    rdy = 1'b1;
    tick(1);
    chk("en_accept_vld", vld_a, 0);

    // gaps: history survives invalid cycles
    do_reset();
    send(5000, 5000, 5000, 15000, 2, 0);
    phase = {14'd5000, 14'd5000, 14'd5000, 14'd5000};
    tick(5);
    send(100, 5000, 5000, 5000, 2, 50);
    tick(3);
    chk("gap_vld", vld_a, 1);
    chk("gap_nsec", nsec_a, 400);
    chk("gap_tai", tai_a, 2);
    tick(2);
    // first word after reset has no lane-0 partner
    send(5000, 5000, 5000, 15000, 2, 0);
    do_reset();
    send(100, 5000, 5000, 5000, 2, 60);
    tick(3);
    chk("rst_first_word_vld", vld_a, 0);
    tick(2);

    // time not valid: no output, counter untouched
    do_reset();
    tvld = 1'b0;
    send(15000, 100, 5000, 5000, 0, 70);
    tick(3);
    chk("tvld0_vld", vld_b, 0);
    tick(1);
    tvld = 1'b1;
    send(15000, 100, 5000, 5000, 0, 80);
    tick(3);
    chk("tvld1_vld", vld_b, 1);
    chk("tvld1_nsec", nsec_b, 642);
    tick(2);

    // reset mid-operation with output pending
    do_reset();
    rdy = 1'b0;
    send(15000, 100, 5000, 5000, 5, 90);
    send(15000, 100, 5000, 5000, 5, 91);
    send(15000, 100, 5000, 5000, 5, 92);
    tick(2);
    chk("rm_pre_vld", vld_b, 1);
    chk("rm_pre_tai", tai_b, 5);
    chk("rm_pre_ovf_a", ovf_a, 1);
    rst_n = 1'b0;
    tick(1);
    chk("rm_vld", vld_b, 0);
    chk("rm_tai", tai_b, 0);
    chk("rm_nsec", nsec_b, 0);
    chk("rm_ovf_a", ovf_a, 0);
    rst_n = 1'b1;
    rdy = 1'b1;
    send(15000, 100, 5000, 5000, 5, 100);
    tick(3);
    chk("rm_post_vld", vld_b, 1);
    chk("rm_post_nsec", nsec_b, 802);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/d3s_frev_timestamper.md
# d3s_frev_timestamper

Transmit-side counterpart of the D3S upsample/divide path. It takes the 4-lanes-per-clock 14-bit RF phase stream, detects phase wraps at 2 ns lane resolution, and divides the wrap rate by the harmonic number. It stamps each selected wrap with WR time (TAI + ns), compensated for latency, and presents it as a frev timestamp on a valid/ready output. The output feeds the frev timestamp inputs of the receive-side divider, locally or through the link.

## Interface
- g_wrap_divider, 5: one timestamp emitted per this many detected wraps (harmonic number), 1..15
- g_latency_comp_ns, 0: ns subtracted from every timestamp, 0..999
- g_wrap_hi, 12288: previous sample must be >= this for a wrap
- g_wrap_lo, 4096: current sample must be < this for a wrap
- clk_i  in  1  clk_wr_ref, 125 MHz (8 ns/cycle)
- rst_n_i  in  1  synchronous, active-low reset
- phase_i  in  56  lane k = bits [14k+:14], lane 0 oldest, lanes 2 ns apart
- phase_valid_i  in  1  phase_i qualifier
- enable_i  in  1  0 = no detection; clears divider counter and overflow_o
- tm_time_valid_i  in  1  WR time valid
- tm_tai_i  in  32  current TAI seconds
- tm_cycles_i  in  28  8 ns cycle count within second, 0..124999999
- frev_ts_tai_o  out  32  timestamp seconds
- frev_ts_nsec_o  out  32  timestamp ns, 0..999999999
- frev_ts_valid_o  out  1  timestamp available
- frev_ts_ready_i  in  1  consumer accepts when valid&ready
- overflow_o  out  1  sticky: timestamp dropped because output was occupied

## Operation
- Lane-3 history register ph3_d plus flag prev_ok. Both update only on valid words. prev_ok is cleared by reset and by enable_i=0.
- Wrap test for a pair (a,b): a >= g_wrap_hi and b < g_wrap_lo. The pairs are (ph3_d,p0) (only if prev_ok), (p0,p1), (p1,p2) and (p2,p3).
- A word is evaluated only when phase_valid_i, enable_i and tm_time_valid_i are all 1. A non-evaluated word changes neither the counter nor the output.
- Several wraps in one word: only the lowest lane index k counts. It counts as one wrap.
- Divider counter cnt in 0..g_wrap_divider-1, reset to 0. On each counted wrap:
  - emit if cnt==0;
  - then cnt <= (cnt+1) mod g_wrap_divider.
  - The first wrap after enable is therefore emitted.
- Raw timestamp: tai = tm_tai_i and ns = tm_cycles_i*8 + 2*k. All time values are those sampled together with the word. Raw ns is at most 999999998.
- Compensation: d = ns - g_latency_comp_ns, computed with at least 33-bit signed arithmetic.
  - If d < 0: ns_out = d + 1000000000 and tai_out = tai - 1 (modulo 2^32).
  - Otherwise: ns_out = d and tai_out = tai.
- Output register, single entry:
  - Load on emit when empty, or when occupied and accepted in the same cycle. A simultaneous accept+load loads the new value, keeps valid=1 and does not overflow.
  - Emit while occupied and not accepted: the new timestamp is dropped, the held one is kept, overflow_o <= 1.
  - Accept without load: valid <= 0.
- Output data is stable while valid=1 and ready=0.
- overflow_o clears only on reset or enable_i=0.
- enable_i=0 does not flush an already-valid output; the output stays until accepted.
- Reset (any time, including with output pending): all outputs 0, cnt=0, prev_ok=0, pipeline flushed.

## Timing
- Pipeline: stage 1 wrap detect/lane encode; stage 2 raw ns and counter decision; stage 3 compensation and output load.
- A word sampled at rising edge t produces frev_ts_valid_o=1 after edge t+3 (visible in cycle t+3).
- Throughput: one word per clock, with no back-pressure on phase_i.
- The counter decision is made in stage 2. Back-to-back wraps in consecutive words are each counted.
- Reset values: frev_ts_tai_o=0, frev_ts_nsec_o=0, frev_ts_valid_o=0, overflow_o=0.

## Test plan
- Basic stamp (N=1, comp=0): ph3_d=15000, then word {p0=16000,p1=200,p2=1200,p3=2200} with tm_tai=7, tm_cycles=100 -> 3 cycles later valid=1, tai=7, nsec=802 (k=1). Wrap across words: ph3_d=15000, p0=100 -> nsec=800.
- Divider (N=5): 10 wrap words at cycles 1000..1009 -> exactly 2 timestamps, from the 1st and 6th wraps (nsec 8000+2k, 8040+2k). Toggle enable_i; the next wrap is emitted.
- Borrow (comp=24): wrap at lane 0, tm_cycles=0, tai=7 -> tai=6, nsec=999999976. Same test with tm_cycles=3 -> tai=7, nsec=0.
- Back-pressure: ready=0, two emits -> first held unchanged, second dropped, overflow_o=1. Ready=1 plus a simultaneous third emit -> third loaded, valid stays 1. Then enable_i=0 -> overflow_o=0.
- Gaps and qualification:
  - p3=15000; 5 cycles with phase_valid_i=0; then p0=100 -> wrap detected at k=0.
  - After reset, first word p0=100 -> no wrap from the lane-0 pair.
  - tm_time_valid_i=0 during a wrap -> no output and cnt unchanged.
- Reset mid-operation: assert rst_n_i=0 while valid=1 and cnt=3 -> next cycle all outputs 0. The next wrap is emitted (cnt was cleared).
